ysyx_040750_wb_stage: RTL and testbench

- Write-back stage: consumer end of the MEM_WB valid/allowin interface.
- Aligns and extends load data, selects the register write value, and drives the regfile and CSR write ports.
- Sequences trap entry (2 cycles) and mret, issuing a PC redirect to the front end.
- Maintains a retired-instruction counter and a commit trace.

---
 rtl/ysyx_040750_wb_stage.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_040750_wb_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040750_wb_stage.sv
// ysyx_040750_wb_stage
// Write-back stage at the consumer end of the MEM_WB valid/allowin handshake.
// Aligns and extends load data, picks the GPR write value and drives the
// regfile and CSR write ports. A trap takes two cycles: the accept cycle
// writes mepc, the following cycle writes mcause and redirects to mtvec.
// mret redirects to mepc in its accept cycle. Also keeps a retire counter
// and a commit trace.
//
// Ports:
//   I_sys_clk, I_rst           clock, synchronous active-high reset
//   I_WB_valid / O_WB_allowin  upstream handshake
//   I_pc .. I_mepc             instruction payload from MEM_WB
//   O_rf_*                     GPR write port
//   O_csr_*                    CSR write port
//   O_redirect, O_redirect_pc  front-end flush and refetch target
//   O_commit_valid/_pc         commit trace
//   O_retire_cnt               retired-instruction count (wraps)
module ysyx_040750_wb_stage #(
    parameter int unsigned XLEN        = 64,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342
) (
    input  logic            I_sys_clk,
    input  logic            I_rst,
    input  logic            I_WB_valid,
    output logic            O_WB_allowin,
    input  logic [31:0]     I_pc,
    input  logic [XLEN-1:0] I_mem_data,
    input  logic [8:0]      I_mem_rstrb,
    input  logic [2:0]      I_mem_shamt,
    input  logic [XLEN-1:0] I_alu_out,
    input  logic            I_reg_wen,
    input  logic [4:0]      I_rd_addr,
    input  logic [1:0]      I_regin_sel,
    input  logic [XLEN-1:0] I_csr_old,
    input  logic [11:0]     I_csr_addr,
    input  logic            I_csr_wen,
    input  logic [XLEN-1:0] I_csr_wdata,
    input  logic            I_csr_intr,
    input  logic [XLEN-1:0] I_csr_intr_no,
    input  logic            I_csr_mret,
    input  logic [31:0]     I_mtvec,
    input  logic [31:0]     I_mepc,
    output logic            O_rf_wen,
    output logic [4:0]      O_rf_waddr,
    output logic [XLEN-1:0] O_rf_wdata,
    output logic            O_csr_wen,
    output logic [11:0]     O_csr_waddr,
    output logic [XLEN-1:0] O_csr_wdata,
    output logic            O_redirect,
    output logic [31:0]     O_redirect_pc,
    output logic            O_commit_valid,
    output logic [31:0]     O_commit_pc,
    output logic [XLEN-1:0] O_retire_cnt
);

    typedef enum logic {
        S_IDLE,
        S_TRAP_CAUSE
    } state_t;

    state_t          state;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] retire_cnt_q;
    logic            accept;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] gpr_data;
    logic [7:0]      byte_keep;
    logic            sign_bit;
    logic            fill_bit;

    assign O_WB_allowin = !I_rst && (state == S_IDLE);
    assign accept       = I_WB_valid && O_WB_allowin;
    assign O_retire_cnt = retire_cnt_q;

    // Load alignment: byte_keep marks every byte up to the highest enabled
    // one; bytes above it take the sign fill, disabled bytes below are zero.
    always_comb begin
        ld_shift  = I_mem_data >> {I_mem_shamt, 3'b000};
        byte_keep = '0;
        sign_bit  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (I_mem_rstrb[i]) begin
                sign_bit = ld_shift[8*i+7];
                for (int unsigned j = 0; j < 8; j++) begin
                    if (j <= i) byte_keep[j] = 1'b1;
                end
            end
        end
        fill_bit = I_mem_rstrb[8] && sign_bit;
        ld_data  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (byte_keep[k])
                ld_data[8*k +: 8] = I_mem_rstrb[k] ? ld_shift[8*k +: 8] : 8'h00;
            else
                ld_data[8*k +: 8] = {8{fill_bit}};
        end
    end

    always_comb begin
        case (I_regin_sel)
            2'b01:   gpr_data = ld_data;
            2'b10:   gpr_data = I_csr_old;
            default: gpr_data = I_alu_out;
        endcase
    end

    // All write/redirect/commit outputs are combinational and forced low
    // during reset, including a reset that lands in TRAP_CAUSE.
    always_comb begin
        O_rf_wen       = 1'b0;
        O_rf_waddr     = '0;
        O_rf_wdata     = '0;
        O_csr_wen      = 1'b0;
        O_csr_waddr    = '0;
        O_csr_wdata    = '0;
        O_redirect     = 1'b0;
        O_redirect_pc  = '0;
        O_commit_valid = 1'b0;
        O_commit_pc    = '0;
        if (!I_rst) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (I_csr_intr) begin
                            O_csr_wen   = 1'b1;
                            O_csr_waddr = MEPC_ADDR;
                            O_csr_wdata = {{(XLEN-32){1'b0}}, I_pc};
                        end else if (I_csr_mret) begin
                            O_redirect     = 1'b1;
                            O_redirect_pc  = I_mepc;
                            O_commit_valid = 1'b1;
                            O_commit_pc    = I_pc;
                        end else begin
                            O_rf_wen       = I_reg_wen && (I_rd_addr != 5'd0);
                            O_rf_waddr     = I_rd_addr;
                            O_rf_wdata     = gpr_data;
                            O_csr_wen      = I_csr_wen;
                            O_csr_waddr    = I_csr_addr;
                            O_csr_wdata    = I_csr_wdata;
                            O_commit_valid = 1'b1;
                            O_commit_pc    = I_pc;
                        end
                    end
                end
                S_TRAP_CAUSE: begin
                    O_csr_wen     = 1'b1;
                    O_csr_waddr   = MCAUSE_ADDR;
                    O_csr_wdata   = cause_q;
                    O_redirect    = 1'b1;
                    O_redirect_pc = I_mtvec;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state        <= S_IDLE;
            cause_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (I_csr_intr) begin
                            cause_q <= I_csr_intr_no;
                            state   <= S_TRAP_CAUSE;
                        end else begin
                            retire_cnt_q <= retire_cnt_q + 1'b1;
                        end
                    end
                end
                S_TRAP_CAUSE: state <= S_IDLE;
                default:      state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_040750_wb_stage.sv
// Self-checking bench for ysyx_040750_wb_stage: directed cases followed by
// randomized traffic, all outputs compared against a transaction-level model.
module tb_ysyx_040750_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        allowin;
    logic [31:0] pc;
    logic [63:0] mem_data;
    logic [8:0]  mem_rstrb;
    logic [2:0]  mem_shamt;
    logic [63:0] alu_out;
    logic        reg_wen;
    logic [4:0]  rd_addr;
    logic [1:0]  regin_sel;
    logic [63:0] csr_old;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [63:0] csr_wdata;
    logic        csr_intr;
    logic [63:0] csr_intr_no;
    logic        csr_mret;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        o_csr_wen;
    logic [11:0] o_csr_waddr;
    logic [63:0] o_csr_wdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [63:0] retire_cnt;

    always #5 clk = ~clk;

    ysyx_040750_wb_stage #(
        .XLEN(64),
        .MEPC_ADDR(12'h341),
        .MCAUSE_ADDR(12'h342)
    ) dut (
        .I_sys_clk(clk), .I_rst(rst), .I_WB_valid(valid), .O_WB_allowin(allowin),
        .I_pc(pc), .I_mem_data(mem_data), .I_mem_rstrb(mem_rstrb),
        .I_mem_shamt(mem_shamt), .I_alu_out(alu_out), .I_reg_wen(reg_wen),
        .I_rd_addr(rd_addr), .I_regin_sel(regin_sel), .I_csr_old(csr_old),
        .I_csr_addr(csr_addr), .I_csr_wen(csr_wen), .I_csr_wdata(csr_wdata),
        .I_csr_intr(csr_intr), .I_csr_intr_no(csr_intr_no), .I_csr_mret(csr_mret),
        .I_mtvec(mtvec), .I_mepc(mepc),
        .O_rf_wen(rf_wen), .O_rf_waddr(rf_waddr), .O_rf_wdata(rf_wdata),
        .O_csr_wen(o_csr_wen), .O_csr_waddr(o_csr_waddr), .O_csr_wdata(o_csr_wdata),
        .O_redirect(redirect), .O_redirect_pc(redirect_pc),
        .O_commit_valid(commit_valid), .O_commit_pc(commit_pc),
        .O_retire_cnt(retire_cnt)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model state: is a trap's second cycle pending, its cause, retire count.
    bit          m_trap_pending;
    logic [63:0] m_cause;
    logic [63:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Load result built byte by byte: take n bytes starting at the offset,
    // zero past the doubleword, then sign-extend from the last taken byte.
    function automatic logic [63:0] ref_load(input logic [63:0] data, input logic [8:0] strb,
                                             input logic [2:0] sh);
        logic [63:0] r;
        int n;
        int idx;
        r = '0;
        case (strb[7:0])
            8'h01:   n = 1;
            8'h03:   n = 2;
            8'h0F:   n = 4;
            8'hFF:   n = 8;
            default: n = 0;
        endcase
        for (int k = 0; k < n; k++) begin
            idx = int'(sh) + k;
            if (idx < 8) r[8*k +: 8] = data[8*idx +: 8];
        end
        if (strb[8] && n > 0 && r[8*n-1]) begin
            for (int k = n; k < 8; k++) r[8*k +: 8] = 8'hFF;
        end
        return r;
    endfunction

    task automatic clr();
        rst = 0; valid = 0; pc = '0; mem_data = '0; mem_rstrb = '0; mem_shamt = '0;
        alu_out = '0; reg_wen = 0; rd_addr = '0; regin_sel = '0; csr_old = '0;
        csr_addr = '0; csr_wen = 0; csr_wdata = '0; csr_intr = 0; csr_intr_no = '0;
        csr_mret = 0; mtvec = '0; mepc = '0;
    endtask

    // Called #1 after a negedge with inputs settled: compare every output
    // against the model, clock once, advance the model, return at negedge.
    task automatic cyc();
        bit          acc;
        bit          e_rfw, e_csrw, e_red, e_com;
        logic [63:0] e_rfd, e_csrd;
        logic [11:0] e_csra;
        logic [31:0] e_redpc;
        logic [63:0] sel_val;
        acc = valid && !rst && !m_trap_pending;
        e_rfw = 0; e_csrw = 0; e_red = 0; e_com = 0;
        e_rfd = '0; e_csrd = '0; e_csra = '0; e_redpc = '0;
        if (!rst) begin
            if (m_trap_pending) begin
                e_csrw = 1; e_csra = 12'h342; e_csrd = m_cause;
                e_red = 1; e_redpc = mtvec;
            end else if (acc && csr_intr) begin
                e_csrw = 1; e_csra = 12'h341; e_csrd = {32'b0, pc};
            end else if (acc && csr_mret) begin
                e_red = 1; e_redpc = mepc; e_com = 1;
            end else if (acc) begin
                if (regin_sel == 2'b01)      sel_val = ref_load(mem_data, mem_rstrb, mem_shamt);
                else if (regin_sel == 2'b10) sel_val = csr_old;
                else                         sel_val = alu_out;
                e_rfw = reg_wen && rd_addr != 0; e_rfd = sel_val;
                e_csrw = csr_wen; e_csra = csr_addr; e_csrd = csr_wdata;
                e_com = 1;
            end
        end
        check("allowin", allowin, !rst && !m_trap_pending);
        check("rf_wen", rf_wen, e_rfw);
        if (e_rfw) begin
            check("rf_waddr", rf_waddr, rd_addr);
            check("rf_wdata", rf_wdata, e_rfd);
        end
        check("csr_wen", o_csr_wen, e_csrw);
        if (e_csrw) begin
            check("csr_waddr", o_csr_waddr, e_csra);
            check("csr_wdata", o_csr_wdata, e_csrd);
        end
        check("redirect", redirect, e_red);
        if (e_red) check("redirect_pc", redirect_pc, e_redpc);
        check("commit_valid", commit_valid, e_com);
        if (e_com) check("commit_pc", commit_pc, pc);
        check("retire_cnt", retire_cnt, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_trap_pending = 0; m_cause = '0; m_cnt = '0;
        end else if (m_trap_pending) begin
            m_trap_pending = 0;
        end else if (acc && csr_intr) begin
            m_trap_pending = 1; m_cause = csr_intr_no;
        end else if (acc) begin
            m_cnt = m_cnt + 1;
        end
        @(negedge clk);
    endtask

    task automatic alu_op(input logic [31:0] p, input logic [63:0] v, input logic [4:0] rd);
        clr(); valid = 1; pc = p; alu_out = v; rd_addr = rd; reg_wen = 1;
    endtask

    initial begin
        logic [7:0] masks [5];
        masks[0] = 8'h00; masks[1] = 8'h01; masks[2] = 8'h03; masks[3] = 8'h0F; masks[4] = 8'hFF;
        m_trap_pending = 0; m_cause = '0; m_cnt = '0;

        clr(); rst = 1; valid = 1;
        @(posedge clk); @(negedge clk); #1;
        cyc();

        // ALU writeback
        alu_op(32'h8000_0000, 64'h1234, 5'd5); #1;
        check("alu_rf_wen", rf_wen, 1'b1);
        check("alu_waddr", rf_waddr, 5'd5);
        check("alu_wdata", rf_wdata, 64'h1234);
        check("alu_commit", commit_valid, 1'b1);
        check("cnt_before", retire_cnt, 64'd0);
        cyc();
        #1 check("cnt_after", retire_cnt, 64'd1);

        // load extraction, signed then unsigned halfword
        clr(); valid = 1; pc = 32'h8000_0004; reg_wen = 1; rd_addr = 5'd7; regin_sel = 2'b01;
        mem_data = 64'h80FF_0000_0000_0000; mem_shamt = 3'd6; mem_rstrb = 9'h103; #1;
        check("lh_signed", rf_wdata, 64'hFFFF_FFFF_FFFF_80FF);
        cyc();
        mem_rstrb = 9'h003; #1;
        check("lhu", rf_wdata, 64'h0000_0000_0000_80FF);
        cyc();

        // write to x0 is dropped but still commits
        alu_op(32'h8000_0008, 64'hDEAD, 5'd0); #1;
        check("x0_rf_wen", rf_wen, 1'b0);
        check("x0_commit", commit_valid, 1'b1);
        cyc();

        // trap entry, upstream valid drops during the second cycle
        clr(); valid = 1; pc = 32'h8000_0010; csr_intr = 1; csr_mret = 1; reg_wen = 1;
        rd_addr = 5'd3; csr_wen = 1; csr_intr_no = 64'h8000_0000_0000_0007; mtvec = 32'h8000_0100; #1;
        check("trap0_allowin", allowin, 1'b1);
        check("trap0_csr_addr", o_csr_waddr, 12'h341);
        check("trap0_csr_data", o_csr_wdata, 64'h8000_0010);
        check("trap0_redirect", redirect, 1'b0);
        cyc();
        valid = 0; #1;
        check("trap1_allowin", allowin, 1'b0);
        check("trap1_csr_addr", o_csr_waddr, 12'h342);
        check("trap1_csr_data", o_csr_wdata, 64'h8000_0000_0000_0007);
        check("trap1_redirect_pc", redirect_pc, 32'h8000_0100);
        check("trap1_commit", commit_valid, 1'b0);
        cyc();

        // mret
        clr(); valid = 1; pc = 32'h8000_0020; csr_mret = 1; mepc = 32'h8000_0044; reg_wen = 1;
        rd_addr = 5'd1; csr_wen = 1; #1;
        check("mret_redirect_pc", redirect_pc, 32'h8000_0044);
        check("mret_commit", commit_valid, 1'b1);
        check("mret_rf_wen", rf_wen, 1'b0);
        cyc();

        // reset in TRAP_CAUSE, then three back-to-back instructions
        clr(); valid = 1; pc = 32'h8000_0030; csr_intr = 1; csr_intr_no = 64'd11; mtvec = 32'h8000_0200; #1;
        cyc();
        rst = 1; #1;
        check("rst_trap_redirect", redirect, 1'b0);
        check("rst_trap_csr_wen", o_csr_wen, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            alu_op(32'h8000_0040 + 4 * i, 64'(i + 100), 5'(i + 1)); #1;
            cyc();
        end
        clr(); #1;
        check("b2b_cnt", retire_cnt, 64'd3);
        check("b2b_allowin", allowin, 1'b1);
        cyc();

        // randomized traffic
        for (int t = 0; t < 600; t++) begin
            clr();
            rst         = ($urandom_range(0, 39) == 0);
            valid       = ($urandom_range(0, 3) != 0);
            pc          = $urandom;
            mem_data    = {$urandom, $urandom};
            mem_rstrb   = {1'($urandom), masks[$urandom_range(0, 4)]};
            mem_shamt   = 3'($urandom);
            alu_out     = {$urandom, $urandom};
            reg_wen     = 1'($urandom);
            rd_addr     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            regin_sel   = 2'($urandom);
            csr_old     = {$urandom, $urandom};
            csr_addr    = 12'($urandom);
            csr_wen     = 1'($urandom);
            csr_wdata   = {$urandom, $urandom};
            csr_intr    = ($urandom_range(0, 7) == 0);
            csr_intr_no = {$urandom, $urandom};
            csr_mret    = ($urandom_range(0, 7) == 0);
            mtvec       = $urandom;
            mepc        = $urandom;
            #1;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
